// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one memory port between the IF fetch path and the MEM data path.
// Each granted access runs IDLE -> BUSY (mem_req held until mem_ack or timeout) -> DONE.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_en_i, if_addr_i            fetch request (held until if_valid_o)
//   if_rdata_o, if_valid_o        fetched word and its one-cycle completion pulse
//   data_en_i, data_we_i,         data request, byte write enables (0 = read),
//   data_addr_i, data_wdata_i     address and store data (held until data_valid_o)
//   data_rdata_o, data_valid_o    load data and its one-cycle completion pulse
//   stall_if_o, stall_mem_o       per-stage stall while a request is outstanding
//   bus_error_o                   pulses with the valid of a timed-out access
//   mem_req_o, mem_we_o,          memory request and latched byte enables,
//   mem_addr_o, mem_wdata_o       address and store data
//   mem_rdata_i, mem_ack_i        memory read data and completion
module fetch_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_en_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,
    output logic                      if_valid_o,
    input  logic                      data_en_i,
    input  logic [DATA_WIDTH/8-1:0]   data_we_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_valid_o,
    output logic                      stall_if_o,
    output logic                      stall_mem_o,
    output logic                      bus_error_o,
    output logic                      mem_req_o,
    output logic [DATA_WIDTH/8-1:0]   mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_ack_i
);

    localparam int SEL   = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic OWN_IF   = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SEL-1:0]          we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    if_valid_q, if_valid_d;
    logic                    data_valid_q, data_valid_d;
    logic                    bus_error_q, bus_error_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q, data_rdata_d;

    logic                    req_any;
    logic                    grant_data;
    logic                    ack_hit;
    logic                    timeout_hit;
    logic [CNT_W-1:0]        cnt_inc;
    logic [DATA_WIDTH-1:0]   rdata_cap;

    assign req_any = if_en_i | data_en_i;

    // On a tie, round-robin hands the port to whoever did not have it last.
    always_comb begin
        if (if_en_i && data_en_i) begin
            grant_data = (DATA_PRIORITY != 0) ? 1'b1 : (last_grant_q == OWN_IF);
        end else begin
            grant_data = data_en_i;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign ack_hit = (state_q == S_BUSY) && mem_ack_i;

    // An ack arriving in the final allowed cycle still wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_BUSY) &&
                         !mem_ack_i && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Stores and timed-out accesses hand back zero rather than bus garbage.
    assign rdata_cap = (timeout_hit || (we_q != '0)) ? '0 : mem_rdata_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE never grants, so a stage still holding its
    // request in the completion cycle is not served twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any) state_d = S_BUSY;
            S_BUSY:  if (ack_hit || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. mem_req decodes straight from the state register, so it
    // is glitch-free and drops as soon as reset is asserted.
    always_comb begin
        mem_req_o = (state_q == S_BUSY);
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign if_rdata_o   = if_rdata_q;
    assign if_valid_o   = if_valid_q;
    assign data_rdata_o = data_rdata_q;
    assign data_valid_o = data_valid_q;
    assign bus_error_o  = bus_error_q;
    assign stall_if_o   = if_en_i & ~if_valid_q;
    assign stall_mem_o  = data_en_i & ~data_valid_q;

    // Request latches, timeout counter and completion registers.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        if_valid_d   = 1'b0;
        data_valid_d = 1'b0;
        bus_error_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        data_rdata_d = data_rdata_q;

        if ((state_q == S_IDLE) && req_any) begin
            owner_d      = grant_data;
            last_grant_d = grant_data;
            cnt_d        = '0;
            if (grant_data) begin
                addr_d  = data_addr_i;
                we_d    = data_we_i;
                wdata_d = data_wdata_i;
            end else begin
                addr_d  = if_addr_i;
                we_d    = '0;
                wdata_d = '0;
            end
        end

        if (state_q == S_BUSY) begin
            cnt_d = cnt_inc;
        end

        if (ack_hit || timeout_hit) begin
            bus_error_d = timeout_hit;
            if (owner_q == OWN_DATA) begin
                data_valid_d = 1'b1;
                data_rdata_d = rdata_cap;
            end else begin
                if_valid_d = 1'b1;
                if_rdata_d = rdata_cap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            addr_q       <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            if_valid_q   <= 1'b0;
            data_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            if_rdata_q   <= '0;
            data_rdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            if_valid_q   <= if_valid_d;
            data_valid_q <= data_valid_d;
            bus_error_q  <= bus_error_d;
            if_rdata_q   <= if_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: dut0 = data priority, timeout 8;
// dut1 = round-robin, no timeout. Checked against a transaction model.
module tb_fetch_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_en [2];
    logic [31:0] if_addr [2];
    logic [31:0] if_rdata [2];
    logic        if_valid [2];
    logic        data_en [2];
    logic [3:0]  data_we [2];
    logic [31:0] data_addr [2];
    logic [31:0] data_wdata [2];
    logic [31:0] data_rdata [2];
    logic        data_valid [2];
    logic        stall_if [2];
    logic        stall_mem [2];
    logic        bus_error [2];
    logic        mem_req [2];
    logic [3:0]  mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ack [2];

    fetch_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .if_en_i(if_en[0]), .if_addr_i(if_addr[0]),
        .if_rdata_o(if_rdata[0]), .if_valid_o(if_valid[0]),
        .data_en_i(data_en[0]), .data_we_i(data_we[0]),
        .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]),
        .data_rdata_o(data_rdata[0]), .data_valid_o(data_valid[0]),
        .stall_if_o(stall_if[0]), .stall_mem_o(stall_mem[0]),
        .bus_error_o(bus_error[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rdata_i(mem_rdata[0]), .mem_ack_i(mem_ack[0])
    );

    fetch_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .DATA_PRIORITY(0), .TIMEOUT_CYCLES(0)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .if_en_i(if_en[1]), .if_addr_i(if_addr[1]),
        .if_rdata_o(if_rdata[1]), .if_valid_o(if_valid[1]),
        .data_en_i(data_en[1]), .data_we_i(data_we[1]),
        .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]),
        .data_rdata_o(data_rdata[1]), .data_valid_o(data_valid[1]),
        .stall_if_o(stall_if[1]), .stall_mem_o(stall_mem[1]),
        .bus_error_o(bus_error[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rdata_i(mem_rdata[1]), .mem_ack_i(mem_ack[1])
    );

    int tests = 0;
    int fails = 0;

    // Requester side of the model.
    bit          req_if [2];
    bit          req_d [2];
    logic [31:0] if_a [2];
    logic [31:0] d_a [2];
    logic [3:0]  d_we [2];
    logic [31:0] d_wd [2];
    bit          auto_on [2];
    bit          persist [2];

    // Access side of the model: one outstanding access per dut.
    bit          act [2];
    bit          dn [2];
    bit          late [2];
    bit          own [2];
    bit          last [2];
    int          cyc [2];
    int          ack_at [2];
    int          fixed_ack [2];
    bit          rd_fix [2];
    logic [31:0] rd_val [2];
    logic [31:0] l_a [2];
    logic [3:0]  l_we [2];
    logic [31:0] l_wd [2];
    bit          e_vif [2];
    bit          e_vd [2];
    bit          e_err [2];
    logic [31:0] e_ird [2];
    logic [31:0] e_drd [2];
    int          rr_log [$];

    function automatic int to_of(int k);
        return (k == 0) ? 8 : 0;
    endfunction

    function automatic bit dp_of(int k);
        return (k == 0);
    endfunction

    task automatic new_data(int k);
        req_d[k] = 1;
        d_a[k]   = $urandom;
        d_we[k]  = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
        d_wd[k]  = $urandom;
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            req_if[k] = 0; req_d[k] = 0;
            if_a[k] = '0; d_a[k] = '0; d_we[k] = '0; d_wd[k] = '0;
            act[k] = 0; dn[k] = 0; late[k] = 0; own[k] = 0; last[k] = 0;
            cyc[k] = 0; ack_at[k] = 0;
            e_vif[k] = 0; e_vd[k] = 0; e_err[k] = 0;
            e_ird[k] = '0; e_drd[k] = '0;
        end
    endtask

    task automatic complete_acc(int k, logic [31:0] v, bit err);
        if (own[k]) begin
            e_vd[k] = 1; e_drd[k] = v;
        end else begin
            e_vif[k] = 1; e_ird[k] = v;
        end
        e_err[k] = err;
        act[k] = 0;
        dn[k] = 1;
    endtask

    // Compare the current cycle against the model, then let requesters react.
    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (mem_req[k] !== act[k]) begin
                fails++;
                $display("FAIL dut%0d mem_req t=%0t got %b want %b", k, $time, mem_req[k], act[k]);
            end
            if (act[k]) begin
                tests++;
                if (mem_addr[k] !== l_a[k] || mem_we[k] !== l_we[k] || mem_wdata[k] !== l_wd[k]) begin
                    fails++;
                    $display("FAIL dut%0d mem_bus t=%0t got %h/%h/%h want %h/%h/%h", k, $time,
                             mem_addr[k], mem_we[k], mem_wdata[k], l_a[k], l_we[k], l_wd[k]);
                end
            end
            tests++;
            if (if_valid[k] !== e_vif[k] || data_valid[k] !== e_vd[k] || bus_error[k] !== e_err[k]) begin
                fails++;
                $display("FAIL dut%0d valids t=%0t got if=%b d=%b err=%b want if=%b d=%b err=%b", k, $time,
                         if_valid[k], data_valid[k], bus_error[k], e_vif[k], e_vd[k], e_err[k]);
            end
            tests++;
            if (if_rdata[k] !== e_ird[k] || data_rdata[k] !== e_drd[k]) begin
                fails++;
                $display("FAIL dut%0d rdata t=%0t got %h/%h want %h/%h", k, $time,
                         if_rdata[k], data_rdata[k], e_ird[k], e_drd[k]);
            end
            tests++;
            if (stall_if[k] !== (req_if[k] && !e_vif[k]) || stall_mem[k] !== (req_d[k] && !e_vd[k])) begin
                fails++;
                $display("FAIL dut%0d stall t=%0t got %b%b want %b%b", k, $time, stall_if[k], stall_mem[k],
                         req_if[k] && !e_vif[k], req_d[k] && !e_vd[k]);
            end
            if (e_vif[k]) begin
                req_if[k] = 0;
                if (persist[k] || (auto_on[k] && $urandom_range(1) == 1)) begin
                    req_if[k] = 1; if_a[k] = $urandom;
                end
            end
            if (e_vd[k]) begin
                req_d[k] = 0;
                if (persist[k] || (auto_on[k] && $urandom_range(1) == 1)) new_data(k);
            end
            if (auto_on[k]) begin
                if (!req_if[k] && $urandom_range(2) == 0) begin
                    req_if[k] = 1; if_a[k] = $urandom;
                end
                if (!req_d[k] && $urandom_range(2) == 0) new_data(k);
            end
        end
    endtask

    // Drive pins for the next edge and predict what that edge does.
    task automatic advance();
        logic        g;
        logic        ack;
        logic [31:0] rdv;
        for (int k = 0; k < 2; k++) begin
            if_en[k] = req_if[k]; if_addr[k] = if_a[k];
            data_en[k] = req_d[k]; data_we[k] = d_we[k];
            data_addr[k] = d_a[k]; data_wdata[k] = d_wd[k];
            rdv = rd_fix[k] ? rd_val[k] : $urandom;
            ack = 0;
            e_vif[k] = 0; e_vd[k] = 0; e_err[k] = 0;
            if (dn[k]) begin
                dn[k] = 0;
                ack = late[k];
                late[k] = 0;
            end else if (act[k]) begin
                cyc[k]++;
                if (cyc[k] == ack_at[k]) begin
                    ack = 1;
                    complete_acc(k, (l_we[k] != 0) ? 32'h0 : rdv, 0);
                end else if (to_of(k) != 0 && cyc[k] == to_of(k)) begin
                    complete_acc(k, 32'h0, 1);
                    late[k] = 1;
                end
            end else begin
                ack = ($urandom_range(3) == 0);
                if (req_if[k] || req_d[k]) begin
                    if (!req_if[k]) g = 1;
                    else if (!req_d[k]) g = 0;
                    else g = dp_of(k) ? 1'b1 : !last[k];
                    own[k] = g; last[k] = g; act[k] = 1; cyc[k] = 0;
                    if (k == 1) rr_log.push_back(int'(g));
                    if (fixed_ack[k] > 0) ack_at[k] = fixed_ack[k];
                    else if (k == 0 && $urandom_range(9) == 0) ack_at[k] = 12;
                    else ack_at[k] = int'($urandom_range(1, 4));
                    l_a[k]  = g ? d_a[k] : if_a[k];
                    l_we[k] = g ? d_we[k] : 4'h0;
                    l_wd[k] = g ? d_wd[k] : 32'h0;
                end
            end
            mem_ack[k] = ack;
            mem_rdata[k] = rdv;
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic settle();
        int n = 0;
        while (n < 100 && (act[0] || dn[0] || req_if[0] || req_d[0] ||
                           act[1] || dn[1] || req_if[1] || req_d[1])) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL settle got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            if_en[k] = 0; if_addr[k] = '0; data_en[k] = 0; data_we[k] = '0;
            data_addr[k] = '0; data_wdata[k] = '0; mem_rdata[k] = '0; mem_ack[k] = 0;
            fixed_ack[k] = 0; rd_fix[k] = 0; rd_val[k] = '0; auto_on[k] = 0; persist[k] = 0;
        end
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({mem_req[k], mem_we[k], mem_addr[k], mem_wdata[k], if_valid[k], data_valid[k],
                 bus_error[k], if_rdata[k], data_rdata[k], stall_if[k], stall_mem[k]} !== '0) begin
                fails++;
                $display("FAIL dut%0d reset_outputs got req=%b valid=%b%b want all zero",
                         k, mem_req[k], if_valid[k], data_valid[k]);
            end
        end
        @(negedge clk);
        rst = 0;
        reset_model();
        advance();
        repeat (3) tick();
    endtask

    task automatic test_fetch_only();
        int nreq = 0;
        int vcyc = -1;
        logic [31:0] got = '0;
        logic st = 1'b1;
        sample();
        fixed_ack[0] = 1; rd_fix[0] = 1; rd_val[0] = 32'h24080001;
        req_if[0] = 1; if_a[0] = 32'hBFC00000;
        advance();
        for (int j = 1; j <= 6; j++) begin
            sample();
            if (mem_req[0]) nreq++;
            if (if_valid[0] && vcyc < 0) begin
                vcyc = j + 1; got = if_rdata[0]; st = stall_if[0];
            end
            advance();
        end
        tests++; if (nreq != 1) begin fails++; $display("FAIL fetch_req_cycles got %0d want 1", nreq); end
        tests++; if (vcyc != 3) begin fails++; $display("FAIL fetch_valid_cycle got %0d want 3", vcyc); end
        tests++; if (got !== 32'h24080001) begin fails++; $display("FAIL fetch_rdata got %h want 24080001", got); end
        tests++; if (st !== 1'b0) begin fails++; $display("FAIL fetch_stall_done got %b want 0", st); end
        fixed_ack[0] = 0; rd_fix[0] = 0;
        settle();
    endtask

    task automatic test_tie_priority();
        logic        rq [9];
        logic [31:0] ad [9];
        logic        dv [9];
        logic        iv [9];
        logic        si [9];
        sample();
        fixed_ack[0] = 1;
        req_if[0] = 1; if_a[0] = 32'h00400020;
        req_d[0] = 1; d_a[0] = 32'h80000010; d_we[0] = 4'h0; d_wd[0] = 32'h11112222;
        advance();
        for (int j = 1; j <= 8; j++) begin
            sample();
            rq[j] = mem_req[0]; ad[j] = mem_addr[0];
            dv[j] = data_valid[0]; iv[j] = if_valid[0]; si[j] = stall_if[0];
            advance();
        end
        tests++;
        if (!(rq[1] === 1'b1 && ad[1] === 32'h80000010)) begin
            fails++; $display("FAIL tie_first_grant got req=%b addr=%h want 1/80000010", rq[1], ad[1]);
        end
        tests++; if (dv[2] !== 1'b1) begin fails++; $display("FAIL tie_data_valid got %b want 1", dv[2]); end
        tests++; if (rq[3] !== 1'b0) begin fails++; $display("FAIL tie_no_regrant got %b want 0", rq[3]); end
        tests++;
        if (!(rq[4] === 1'b1 && ad[4] === 32'h00400020)) begin
            fails++; $display("FAIL tie_fetch_grant got req=%b addr=%h want 1/00400020", rq[4], ad[4]);
        end
        tests++; if (iv[5] !== 1'b1) begin fails++; $display("FAIL tie_if_valid got %b want 1", iv[5]); end
        tests++;
        if ({si[1], si[2], si[3], si[4]} !== 4'b1111) begin
            fails++; $display("FAIL tie_stall_if got %b%b%b%b want 1111", si[1], si[2], si[3], si[4]);
        end
        fixed_ack[0] = 0;
        settle();
    endtask

    task automatic test_round_robin();
        int n = 0;
        sample();
        fixed_ack[1] = 1;
        new_data(1);
        advance();
        settle();
        sample();
        rr_log.delete();
        persist[1] = 1;
        req_if[1] = 1; if_a[1] = $urandom;
        new_data(1);
        advance();
        while (n < 40 && rr_log.size() < 4) begin
            tick();
            n++;
        end
        persist[1] = 0;
        tests++;
        if (rr_log.size() < 4) begin
            fails++; $display("FAIL rr_grants got %0d want 4", rr_log.size());
        end else begin
            tests++;
            if (rr_log[0] != 0 || rr_log[1] != 1 || rr_log[2] != 0 || rr_log[3] != 1) begin
                fails++;
                $display("FAIL rr_order got %0d%0d%0d%0d want 0101 (0=IF)",
                         rr_log[0], rr_log[1], rr_log[2], rr_log[3]);
            end
        end
        fixed_ack[1] = 0;
        settle();
    endtask

    task automatic test_store();
        int nreq = 0;
        int nstab = 0;
        int vcyc = -1;
        logic [31:0] rd = 32'hFFFFFFFF;
        logic err = 1'b1;
        logic [31:0] a;
        a = $urandom;
        sample();
        fixed_ack[0] = 5; rd_fix[0] = 1; rd_val[0] = 32'hDEADBEEF;
        req_d[0] = 1; d_a[0] = a; d_we[0] = 4'b0011; d_wd[0] = 32'h0000BEEF;
        advance();
        for (int j = 1; j <= 9; j++) begin
            sample();
            if (mem_req[0]) begin
                nreq++;
                if (mem_we[0] === 4'b0011 && mem_wdata[0] === 32'h0000BEEF && mem_addr[0] === a) nstab++;
            end
            if (data_valid[0] && vcyc < 0) begin
                vcyc = j; rd = data_rdata[0]; err = bus_error[0];
            end
            advance();
        end
        tests++; if (nreq != 5) begin fails++; $display("FAIL store_req_cycles got %0d want 5", nreq); end
        tests++; if (nstab != 5) begin fails++; $display("FAIL store_bus_stable got %0d want 5", nstab); end
        tests++; if (vcyc != 6) begin fails++; $display("FAIL store_valid_cycle got %0d want 6", vcyc); end
        tests++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            fails++; $display("FAIL store_result got rdata=%h err=%b want 0/0", rd, err);
        end
        fixed_ack[0] = 0; rd_fix[0] = 0;
        settle();
    endtask

    task automatic test_timeout();
        int nreq = 0;
        int nval = 0;
        int vcyc = -1;
        logic [31:0] rd = 32'hFFFFFFFF;
        logic err = 1'b0;
        sample();
        fixed_ack[0] = 12; rd_fix[0] = 1; rd_val[0] = 32'h12345678;
        req_if[0] = 1; if_a[0] = 32'h00001000;
        advance();
        for (int j = 1; j <= 13; j++) begin
            sample();
            if (mem_req[0]) nreq++;
            if (if_valid[0]) begin
                nval++;
                if (vcyc < 0) begin vcyc = j; rd = if_rdata[0]; err = bus_error[0]; end
            end
            advance();
        end
        tests++; if (nreq != 8) begin fails++; $display("FAIL timeout_req_cycles got %0d want 8", nreq); end
        tests++; if (vcyc != 9) begin fails++; $display("FAIL timeout_valid_cycle got %0d want 9", vcyc); end
        tests++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            fails++; $display("FAIL timeout_result got rdata=%h err=%b want 0/1", rd, err);
        end
        tests++; if (nval != 1) begin fails++; $display("FAIL timeout_late_ack got %0d valids want 1", nval); end
        fixed_ack[0] = 0; rd_fix[0] = 0;
        settle();
    endtask

    task automatic test_reset_mid_busy();
        int vcyc = -1;
        logic [31:0] got = '0;
        sample();
        fixed_ack[0] = 6;
        req_if[0] = 1; if_a[0] = 32'h00002000;
        advance();
        tick();
        sample();
        advance();
        #2 rst = 1;
        #1;
        tests++;
        if (mem_req[0] !== 1'b0 || mem_req[1] !== 1'b0) begin
            fails++; $display("FAIL rst_async_req got %b%b want 00", mem_req[0], mem_req[1]);
        end
        @(negedge clk);
        rst = 0;
        reset_model();
        fixed_ack[0] = 1; rd_fix[0] = 1; rd_val[0] = 32'hCAFEF00D;
        req_if[0] = 1; if_a[0] = 32'hBFC00004;
        advance();
        for (int j = 1; j <= 4; j++) begin
            sample();
            if (if_valid[0] && vcyc < 0) begin vcyc = j + 1; got = if_rdata[0]; end
            advance();
        end
        tests++;
        if (vcyc != 3 || got !== 32'hCAFEF00D) begin
            fails++; $display("FAIL rst_refetch got cycle=%0d rdata=%h want 3/cafef00d", vcyc, got);
        end
        fixed_ack[0] = 0; rd_fix[0] = 0;
        settle();
    endtask

    task automatic test_random();
        auto_on[0] = 1; auto_on[1] = 1;
        repeat (3000) tick();
        auto_on[0] = 0; auto_on[1] = 0;
        settle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_tie_priority();
        test_round_robin();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
